// File: rtl/axi4_mem_tester.sv
// AXI4 initiator that writes NUM_BURSTS INCR bursts of a seeded address pattern,
// reads them back and checks every beat, with one transaction outstanding at a time.
module axi4_mem_tester #(
  parameter int                   ADDR_BITS  = 32,
  parameter int                   DATA_BITS  = 64,
  parameter int                   ID_BITS    = 5,
  parameter int                   BEATS      = 8,
  parameter int                   NUM_BURSTS = 16,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR  = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_start,
  input  logic [31:0]            io_seed,
  output logic                   io_busy,
  output logic                   io_done,
  output logic                   io_pass,
  output logic [15:0]            io_error_count,
  output logic [ADDR_BITS-1:0]   io_fail_addr,
  output logic                   axi_aw_valid,
  input  logic                   axi_aw_ready,
  output logic [ADDR_BITS-1:0]   axi_aw_bits_addr,
  output logic [7:0]             axi_aw_bits_len,
  output logic [2:0]             axi_aw_bits_size,
  output logic [ID_BITS-1:0]     axi_aw_bits_id,
  output logic [1:0]             axi_aw_bits_burst,
  output logic                   axi_aw_bits_lock,
  output logic [3:0]             axi_aw_bits_cache,
  output logic [2:0]             axi_aw_bits_prot,
  output logic [3:0]             axi_aw_bits_qos,
  output logic                   axi_w_valid,
  input  logic                   axi_w_ready,
  output logic [DATA_BITS-1:0]   axi_w_bits_data,
  output logic [DATA_BITS/8-1:0] axi_w_bits_strb,
  output logic                   axi_w_bits_last,
  input  logic                   axi_b_valid,
  output logic                   axi_b_ready,
  input  logic [1:0]             axi_b_bits_resp,
  input  logic [ID_BITS-1:0]     axi_b_bits_id,
  output logic                   axi_ar_valid,
  input  logic                   axi_ar_ready,
  output logic [ADDR_BITS-1:0]   axi_ar_bits_addr,
  output logic [7:0]             axi_ar_bits_len,
  output logic [2:0]             axi_ar_bits_size,
  output logic [ID_BITS-1:0]     axi_ar_bits_id,
  output logic [1:0]             axi_ar_bits_burst,
  output logic                   axi_ar_bits_lock,
  output logic [3:0]             axi_ar_bits_cache,
  output logic [2:0]             axi_ar_bits_prot,
  output logic [3:0]             axi_ar_bits_qos,
  input  logic                   axi_r_valid,
  output logic                   axi_r_ready,
  input  logic [DATA_BITS-1:0]   axi_r_bits_data,
  input  logic [1:0]             axi_r_bits_resp,
  input  logic                   axi_r_bits_last,
  input  logic [ID_BITS-1:0]     axi_r_bits_id
);

  localparam int BYTES = DATA_BITS / 8;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int NW    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [KW-1:0]        K_LAST     = KW'(BEATS - 1);
  localparam logic [NW-1:0]        N_LAST     = NW'(NUM_BURSTS - 1);
  localparam logic [ADDR_BITS-1:0] BEAT_STEP  = ADDR_BITS'(BYTES);
  localparam logic [ADDR_BITS-1:0] BURST_STEP = ADDR_BITS'(BEATS * BYTES);
  localparam logic [7:0]           LEN        = 8'(BEATS - 1);
  localparam logic [2:0]           SIZE       = 3'($clog2(BYTES));

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  state_t                 r_state, w_next;
  logic [31:0]            r_seed;
  logic [NW-1:0]          r_n;
  logic [KW-1:0]          r_k;
  logic [ADDR_BITS-1:0]   r_burstAddr;
  logic [ADDR_BITS-1:0]   r_beatAddr;
  logic [15:0]            r_errCount;
  logic [ADDR_BITS-1:0]   r_failAddr;

  logic                   w_awFire, w_wFire, w_bFire, w_arFire, w_rFire;
  logic                   w_err;
  logic [ADDR_BITS-1:0]   w_errAddr;
  logic                   w_lastBeat, w_lastBurst, w_start;
  logic [31:0]            w_pattern;
  logic [DATA_BITS-1:0]   w_expData;
  logic [ID_BITS-1:0]     w_id;

  assign w_lastBeat  = (r_k == K_LAST);
  assign w_lastBurst = (r_n == N_LAST);
  assign w_start     = io_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_pattern   = 32'(r_beatAddr) ^ r_seed;
  assign w_expData   = {(DATA_BITS/32){w_pattern}};
  assign w_id        = ID_BITS'(r_n);

  assign io_busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign io_done        = (r_state == S_DONE);
  assign io_pass        = io_done && (r_errCount == 16'd0);
  assign io_error_count = r_errCount;
  assign io_fail_addr   = r_failAddr;

  assign axi_aw_bits_addr  = r_burstAddr;
  assign axi_aw_bits_len   = LEN;
  assign axi_aw_bits_size  = SIZE;
  assign axi_aw_bits_id    = w_id;
  assign axi_aw_bits_burst = 2'b01;
  assign axi_aw_bits_lock  = 1'b0;
  assign axi_aw_bits_cache = 4'd0;
  assign axi_aw_bits_prot  = 3'd0;
  assign axi_aw_bits_qos   = 4'd0;
  assign axi_ar_bits_addr  = r_burstAddr;
  assign axi_ar_bits_len   = LEN;
  assign axi_ar_bits_size  = SIZE;
  assign axi_ar_bits_id    = w_id;
  assign axi_ar_bits_burst = 2'b01;
  assign axi_ar_bits_lock  = 1'b0;
  assign axi_ar_bits_cache = 4'd0;
  assign axi_ar_bits_prot  = 3'd0;
  assign axi_ar_bits_qos   = 4'd0;
  assign axi_w_bits_data   = w_expData;
  assign axi_w_bits_strb   = '1;
  assign axi_w_bits_last   = w_lastBeat;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Valids and readies depend only on the registered state, never on inputs.
  always_comb begin
    w_next       = r_state;
    axi_aw_valid = 1'b0;
    axi_w_valid  = 1'b0;
    axi_b_ready  = 1'b0;
    axi_ar_valid = 1'b0;
    axi_r_ready  = 1'b0;
    w_awFire     = 1'b0;
    w_wFire      = 1'b0;
    w_bFire      = 1'b0;
    w_arFire     = 1'b0;
    w_rFire      = 1'b0;
    w_err        = 1'b0;
    w_errAddr    = r_beatAddr;
    case (r_state)
      S_IDLE, S_DONE: if (io_start) w_next = S_AW;
      S_AW: begin
        axi_aw_valid = 1'b1;
        if (axi_aw_ready) begin
          w_awFire = 1'b1;
          w_next   = S_W;
        end
      end
      S_W: begin
        axi_w_valid = 1'b1;
        if (axi_w_ready) begin
          w_wFire = 1'b1;
          if (w_lastBeat) w_next = S_B;
        end
      end
      S_B: begin
        axi_b_ready = 1'b1;
        if (axi_b_valid) begin
          w_bFire   = 1'b1;
          w_err     = (axi_b_bits_resp != 2'd0) || (axi_b_bits_id != w_id);
          w_errAddr = r_burstAddr;
          w_next    = w_lastBurst ? S_AR : S_AW;
        end
      end
      S_AR: begin
        axi_ar_valid = 1'b1;
        if (axi_ar_ready) begin
          w_arFire = 1'b1;
          w_next   = S_R;
        end
      end
      S_R: begin
        axi_r_ready = 1'b1;
        if (axi_r_valid) begin
          w_rFire = 1'b1;
          w_err   = (axi_r_bits_data != w_expData) || (axi_r_bits_resp != 2'd0) ||
                    (axi_r_bits_id != w_id) || (axi_r_bits_last != w_lastBeat);
          if (w_lastBeat) w_next = w_lastBurst ? S_DONE : S_AR;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Burst/beat bookkeeping; a read burst ends on its counted last beat whatever rlast says.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_seed      <= 32'd0;
      r_n         <= '0;
      r_k         <= '0;
      r_burstAddr <= BASE_ADDR;
      r_beatAddr  <= BASE_ADDR;
      r_errCount  <= 16'd0;
      r_failAddr  <= '0;
    end else begin
      if (w_start) begin
        r_seed      <= io_seed;
        r_errCount  <= 16'd0;
        r_failAddr  <= '0;
        r_n         <= '0;
        r_burstAddr <= BASE_ADDR;
      end
      if (w_awFire || w_arFire) begin
        r_k        <= '0;
        r_beatAddr <= r_burstAddr;
      end
      if (w_wFire || w_rFire) begin
        r_k        <= r_k + 1'b1;
        r_beatAddr <= r_beatAddr + BEAT_STEP;
      end
      if (w_bFire || (w_rFire && w_lastBeat)) begin
        if (w_lastBurst) begin
          r_n         <= '0;
          r_burstAddr <= BASE_ADDR;
        end else begin
          r_n         <= r_n + 1'b1;
          r_burstAddr <= r_burstAddr + BURST_STEP;
        end
      end
      if (w_err) begin
        if (r_errCount != 16'hFFFF) r_errCount <= r_errCount + 1'b1;
        if (r_errCount == 16'd0)    r_failAddr <= w_errAddr;
      end
    end
  end

endmodule

// File: tb/tb_axi4_mem_tester.sv
// Directed bench for axi4_mem_tester: a memory responder with optional stalls and
// injected faults, plus hand-computed expectations for each scenario.
module tb_axi4_mem_tester;

  localparam int AB = 32, DB = 64, IB = 5, NBEATS = 4, NBURSTS = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic           io_start, io_busy, io_done, io_pass;
  logic [31:0]    io_seed;
  logic [15:0]    io_error_count;
  logic [AB-1:0]  io_fail_addr;
  logic           axi_aw_valid, axi_aw_ready, axi_aw_bits_lock;
  logic [AB-1:0]  axi_aw_bits_addr;
  logic [7:0]     axi_aw_bits_len;
  logic [2:0]     axi_aw_bits_size, axi_aw_bits_prot;
  logic [IB-1:0]  axi_aw_bits_id;
  logic [1:0]     axi_aw_bits_burst;
  logic [3:0]     axi_aw_bits_cache, axi_aw_bits_qos;
  logic           axi_w_valid, axi_w_ready, axi_w_bits_last;
  logic [DB-1:0]  axi_w_bits_data;
  logic [DB/8-1:0] axi_w_bits_strb;
  logic           axi_b_valid, axi_b_ready;
  logic [1:0]     axi_b_bits_resp;
  logic [IB-1:0]  axi_b_bits_id;
  logic           axi_ar_valid, axi_ar_ready, axi_ar_bits_lock;
  logic [AB-1:0]  axi_ar_bits_addr;
  logic [7:0]     axi_ar_bits_len;
  logic [2:0]     axi_ar_bits_size, axi_ar_bits_prot;
  logic [IB-1:0]  axi_ar_bits_id;
  logic [1:0]     axi_ar_bits_burst;
  logic [3:0]     axi_ar_bits_cache, axi_ar_bits_qos;
  logic           axi_r_valid, axi_r_ready, axi_r_bits_last;
  logic [DB-1:0]  axi_r_bits_data;
  logic [1:0]     axi_r_bits_resp;
  logic [IB-1:0]  axi_r_bits_id;

  axi4_mem_tester #(.ADDR_BITS(AB), .DATA_BITS(DB), .ID_BITS(IB), .BEATS(NBEATS),
                    .NUM_BURSTS(NBURSTS), .BASE_ADDR(32'h0)) dut (
    .clock(clock), .reset(reset), .io_start(io_start), .io_seed(io_seed),
    .io_busy(io_busy), .io_done(io_done), .io_pass(io_pass),
    .io_error_count(io_error_count), .io_fail_addr(io_fail_addr),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
    .axi_aw_bits_addr(axi_aw_bits_addr), .axi_aw_bits_len(axi_aw_bits_len),
    .axi_aw_bits_size(axi_aw_bits_size), .axi_aw_bits_id(axi_aw_bits_id),
    .axi_aw_bits_burst(axi_aw_bits_burst), .axi_aw_bits_lock(axi_aw_bits_lock),
    .axi_aw_bits_cache(axi_aw_bits_cache), .axi_aw_bits_prot(axi_aw_bits_prot),
    .axi_aw_bits_qos(axi_aw_bits_qos),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
    .axi_w_bits_data(axi_w_bits_data), .axi_w_bits_strb(axi_w_bits_strb),
    .axi_w_bits_last(axi_w_bits_last),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready),
    .axi_b_bits_resp(axi_b_bits_resp), .axi_b_bits_id(axi_b_bits_id),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
    .axi_ar_bits_addr(axi_ar_bits_addr), .axi_ar_bits_len(axi_ar_bits_len),
    .axi_ar_bits_size(axi_ar_bits_size), .axi_ar_bits_id(axi_ar_bits_id),
    .axi_ar_bits_burst(axi_ar_bits_burst), .axi_ar_bits_lock(axi_ar_bits_lock),
    .axi_ar_bits_cache(axi_ar_bits_cache), .axi_ar_bits_prot(axi_ar_bits_prot),
    .axi_ar_bits_qos(axi_ar_bits_qos),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready),
    .axi_r_bits_data(axi_r_bits_data), .axi_r_bits_resp(axi_r_bits_resp),
    .axi_r_bits_last(axi_r_bits_last), .axi_r_bits_id(axi_r_bits_id)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Responder configuration and state, shared between the main sequence and the responder.
  int          readyPct = 100, validPct = 100;
  bit          flipFault, bRespFault, lastFault, holdBeat2;
  logic [31:0] curSeed;
  logic [63:0] mem [logic [31:0]];
  int          wrN, arN, wBeat, wBurst, wTotal, bPending, bBurst, rBeat, rBurst;
  logic [31:0] wAddr, rAddr;
  logic [IB-1:0] bId, rId;
  bit          rActive, bFire, rFire, pAwStall, pWStall, pArStall, pWLast;
  logic [31:0] pAwAddr, pArAddr;
  logic [63:0] pWData;
  logic [63:0] wLog [8];
  logic [31:0] awLog [2];

  function automatic bit chance(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  function automatic logic [63:0] pattern(input logic [31:0] addr, input logic [31:0] seed);
    return {2{addr ^ seed}};
  endfunction

  task automatic responderStep();
    logic [31:0] a;
    if (reset) begin
      axi_aw_ready = 0; axi_w_ready = 0; axi_ar_ready = 0; axi_b_valid = 0; axi_r_valid = 0;
      pAwStall = 0; pWStall = 0; pArStall = 0; bFire = 0; rFire = 0;
      bPending = 0; rActive = 0; wBeat = 0;
      return;
    end
    if (pAwStall) begin
      checkOutput("aw_hold_valid", 64'(axi_aw_valid), 64'd1);
      checkOutput("aw_hold_addr", 64'(axi_aw_bits_addr), 64'(pAwAddr));
    end
    if (pWStall) begin
      checkOutput("w_hold_valid", 64'(axi_w_valid), 64'd1);
      checkOutput("w_hold_data", axi_w_bits_data, pWData);
      checkOutput("w_hold_last", 64'(axi_w_bits_last), 64'(pWLast));
    end
    if (pArStall) begin
      checkOutput("ar_hold_valid", 64'(axi_ar_valid), 64'd1);
      checkOutput("ar_hold_addr", 64'(axi_ar_bits_addr), 64'(pArAddr));
    end
    if (bFire) axi_b_valid = 0;
    if (bPending > 0 && !axi_b_valid && chance(validPct)) begin
      axi_b_valid = 1;
      axi_b_bits_id = bId;
      axi_b_bits_resp = (bRespFault && bBurst == 1) ? 2'd2 : 2'd0;
      bPending--;
    end
    if (rFire) begin
      axi_r_valid = 0;
      rBeat++;
      if (rBeat == NBEATS) rActive = 0;
    end
    if (rActive && !axi_r_valid && chance(validPct)) begin
      a = rAddr + 32'(rBeat * 8);
      axi_r_bits_data = mem.exists(a) ? mem[a] : 64'd0;
      if (flipFault && a == 32'h28) axi_r_bits_data[0] = ~axi_r_bits_data[0];
      axi_r_bits_last = (lastFault && rBurst == 0) ? (rBeat == 2) : (rBeat == NBEATS - 1);
      axi_r_bits_resp = 2'd0;
      axi_r_bits_id = rId;
      axi_r_valid = 1;
    end
    axi_aw_ready = chance(readyPct);
    axi_w_ready  = chance(readyPct) && !(holdBeat2 && wBeat == 2);
    axi_ar_ready = chance(readyPct);
    if (axi_aw_valid && axi_aw_ready) begin
      checkOutput("aw_addr", 64'(axi_aw_bits_addr), 64'(wrN * 32));
      checkOutput("aw_len", 64'(axi_aw_bits_len), 64'd3);
      checkOutput("aw_size", 64'(axi_aw_bits_size), 64'd3);
      checkOutput("aw_id", 64'(axi_aw_bits_id), 64'(wrN));
      checkOutput("aw_burst", 64'(axi_aw_bits_burst), 64'd1);
      if (wrN < 2) awLog[wrN] = axi_aw_bits_addr;
      wAddr = 32'(wrN * 32); wBeat = 0; wBurst = wrN; wrN++;
    end
    if (axi_w_valid && axi_w_ready) begin
      a = wAddr + 32'(wBeat * 8);
      checkOutput("w_data", axi_w_bits_data, pattern(a, curSeed));
      checkOutput("w_strb", 64'(axi_w_bits_strb), 64'hFF);
      checkOutput("w_last", 64'(axi_w_bits_last), 64'(wBeat == NBEATS - 1));
      mem[a] = axi_w_bits_data;
      if (wTotal < 8) wLog[wTotal] = axi_w_bits_data;
      wTotal++;
      if (wBeat == NBEATS - 1) begin
        bPending++; bBurst = wBurst; bId = IB'(wBurst);
      end
      wBeat++;
    end
    if (axi_ar_valid && axi_ar_ready) begin
      checkOutput("ar_addr", 64'(axi_ar_bits_addr), 64'(arN * 32));
      checkOutput("ar_len", 64'(axi_ar_bits_len), 64'd3);
      checkOutput("ar_size", 64'(axi_ar_bits_size), 64'd3);
      checkOutput("ar_id", 64'(axi_ar_bits_id), 64'(arN));
      rAddr = 32'(arN * 32); rId = IB'(arN); rBurst = arN; rBeat = 0; rActive = 1; arN++;
    end
    bFire = axi_b_valid && axi_b_ready;
    rFire = axi_r_valid && axi_r_ready;
    pAwStall = axi_aw_valid && !axi_aw_ready; pAwAddr = axi_aw_bits_addr;
    pWStall  = axi_w_valid && !axi_w_ready;   pWData = axi_w_bits_data; pWLast = axi_w_bits_last;
    pArStall = axi_ar_valid && !axi_ar_ready; pArAddr = axi_ar_bits_addr;
  endtask

  initial begin
    forever begin
      @(negedge clock);
      #1;
      responderStep();
    end
  end

  task automatic launch(input logic [31:0] seed, input int rdy, input int vld,
                        input bit flip, input bit bErr, input bit lastErr);
    readyPct = rdy; validPct = vld; flipFault = flip; bRespFault = bErr; lastFault = lastErr;
    curSeed = seed; wrN = 0; arN = 0; wTotal = 0; mem.delete();
    io_seed = seed; io_start = 1;
    @(negedge clock);
    io_start = 0;
    checkOutput("aw_valid_after_start", 64'(axi_aw_valid), 64'd1);
    checkOutput("busy_after_start", 64'(io_busy), 64'd1);
    checkOutput("done_cleared", 64'(io_done), 64'd0);
  endtask

  task automatic applyStimulus(input logic [31:0] seed, input int rdy, input int vld,
                               input bit flip, input bit bErr, input bit lastErr, input bit busyStart);
    launch(seed, rdy, vld, flip, bErr, lastErr);
    for (int c = 0; c < 4000; c++) begin
      if (busyStart && c == 10) begin io_seed = 32'h12345678; io_start = 1; end
      if (busyStart && c == 11) io_start = 0;
      if (io_done) break;
      @(negedge clock);
    end
    io_start = 0;
    checkOutput("done", 64'(io_done), 64'd1);
    checkOutput("busy_clear", 64'(io_busy), 64'd0);
    checkOutput("ar_bursts", 64'(arN), 64'd2);
  endtask

  task automatic checkResult(input string tag, input bit pass, input int errs, input logic [31:0] fail);
    checkOutput({tag, "_pass"}, 64'(io_pass), 64'(pass));
    checkOutput({tag, "_errors"}, 64'(io_error_count), 64'(errs));
    if (!pass) checkOutput({tag, "_fail_addr"}, 64'(io_fail_addr), 64'(fail));
  endtask

  initial begin
    bit hit;
    io_start = 0; io_seed = 0;
    axi_aw_ready = 0; axi_w_ready = 0; axi_ar_ready = 0;
    axi_b_valid = 0; axi_b_bits_resp = 0; axi_b_bits_id = 0;
    axi_r_valid = 0; axi_r_bits_data = 0; axi_r_bits_resp = 0; axi_r_bits_last = 0; axi_r_bits_id = 0;
    repeat (3) @(negedge clock);
    checkOutput("rst_aw_valid", 64'(axi_aw_valid), 64'd0);
    checkOutput("rst_w_valid", 64'(axi_w_valid), 64'd0);
    checkOutput("rst_ar_valid", 64'(axi_ar_valid), 64'd0);
    checkOutput("rst_b_ready", 64'(axi_b_ready), 64'd0);
    checkOutput("rst_r_ready", 64'(axi_r_ready), 64'd0);
    checkOutput("rst_busy", 64'(io_busy), 64'd0);
    checkOutput("rst_done", 64'(io_done), 64'd0);
    checkOutput("rst_pass", 64'(io_pass), 64'd0);
    checkOutput("rst_errors", 64'(io_error_count), 64'd0);
    checkOutput("rst_fail_addr", 64'(io_fail_addr), 64'd0);
    reset = 0;
    @(negedge clock);

    $display("[TB] clean run, always-ready responder");
    applyStimulus(32'hA5A5A5A5, 100, 100, 0, 0, 0, 0);
    checkResult("clean", 1, 0, 0);
    checkOutput("clean_fail_addr", 64'(io_fail_addr), 64'd0);
    checkOutput("aw0_addr", 64'(awLog[0]), 64'h0);
    checkOutput("aw1_addr", 64'(awLog[1]), 64'h20);
    checkOutput("w_beat0", wLog[0], 64'hA5A5A5A5A5A5A5A5);
    checkOutput("w_beat1", wLog[1], 64'hA5A5A5ADA5A5A5AD);
    repeat (3) @(negedge clock);
    checkOutput("done_sticky", 64'(io_done), 64'd1);

    $display("[TB] read data bit flip at 0x28");
    applyStimulus(32'hA5A5A5A5, 100, 100, 1, 0, 0, 0);
    checkResult("flip", 0, 1, 32'h28);

    $display("[TB] random stalls with an ignored start while busy");
    applyStimulus(32'hA5A5A5A5, 30, 50, 0, 0, 0, 1);
    checkResult("stall", 1, 0, 0);

    $display("[TB] write response error on burst 1");
    applyStimulus(32'hA5A5A5A5, 100, 100, 0, 1, 0, 0);
    checkResult("bresp", 0, 1, 32'h20);

    $display("[TB] early rlast on read burst 0");
    applyStimulus(32'h0F0F1234, 100, 100, 0, 0, 1, 0);
    checkResult("rlast", 0, 2, 32'h10);

    $display("[TB] reset during write beat 2");
    holdBeat2 = 1;
    launch(32'hA5A5A5A5, 100, 100, 0, 0, 0);
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clock);
      #2;
      if (axi_w_valid && wBeat == 2) hit = 1;
    end
    checkOutput("reached_w_beat2", 64'(hit), 64'd1);
    reset = 1;
    @(negedge clock);
    checkOutput("abort_aw_valid", 64'(axi_aw_valid), 64'd0);
    checkOutput("abort_w_valid", 64'(axi_w_valid), 64'd0);
    checkOutput("abort_ar_valid", 64'(axi_ar_valid), 64'd0);
    checkOutput("abort_b_ready", 64'(axi_b_ready), 64'd0);
    checkOutput("abort_r_ready", 64'(axi_r_ready), 64'd0);
    checkOutput("abort_busy", 64'(io_busy), 64'd0);
    checkOutput("abort_done", 64'(io_done), 64'd0);
    @(negedge clock);
    reset = 0;
    holdBeat2 = 0;
    @(negedge clock);
    applyStimulus(32'hA5A5A5A5, 100, 100, 0, 0, 0, 0);
    checkResult("after_reset", 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/axi4_mem_tester.md
Name: axi4_mem_tester

Overview:
AXI4 initiator that drives a full-bus memory responder, such as the team's DRAM simulation model, with a deterministic write-then-readback test.
- Write phase: issues NUM_BURSTS INCR write bursts.
- Read phase: reads every burst back, checks each beat against the regenerated pattern, and reports pass/fail.
- Sits at the harness level in place of, or beside, the SoC memory port as a self-checking memory-path exerciser.

Parameters:
ADDR_BITS, 32, AXI address width
DATA_BITS, 64, AXI data width; multiple of 32, at most 512
ID_BITS, 5, AXI id width
BEATS, 8, beats per burst, 1..256
NUM_BURSTS, 16, bursts per test, at least 1
BASE_ADDR, 0, first byte address; aligned to BEATS*DATA_BITS/8

Ports:
clock  input  1  sole clock
reset  input  1  synchronous, active-high
io_start  input  1  one-cycle pulse that starts a test; ignored unless idle
io_seed  input  32  pattern seed, sampled on an accepted start
io_busy  output  1  test in progress
io_done  output  1  sticky high after completion; cleared by the next start
io_pass  output  1  valid while io_done; 1 iff error count is 0
io_error_count  output  16  saturating error count
io_fail_addr  output  ADDR_BITS  beat address of the first error
axi_aw_valid / axi_aw_bits_addr / _len[8] / _size[3] / _id  output  write address channel
axi_aw_ready  input  1
axi_aw_bits_burst[2]=1, _lock=0, _cache[4]=0, _prot[3]=0, _qos[4]=0  output  constants; same constants on the AR channel
axi_w_valid / axi_w_bits_data / _strb[DATA_BITS/8] / _last  output  write data channel
axi_w_ready  input  1
axi_b_valid / axi_b_bits_resp[2] / axi_b_bits_id  input  write response channel
axi_b_ready  output  1
axi_ar_valid / axi_ar_bits_addr / _len / _size / _id  output  read address channel
axi_ar_ready  input  1
axi_r_valid / axi_r_bits_data / _resp[2] / _last / _id  input  read data channel
axi_r_ready  output  1

Behaviour:
- Reset values: all valids 0; b_ready 0; r_ready 0; io_busy 0; io_done 0; io_pass 0; io_error_count 0; io_fail_addr 0. Reset asserted mid-test aborts the test: next cycle the FSM is IDLE and all valids are 0, regardless of outstanding handshakes.
- FSM states: IDLE, AW, W, B, AR, R, DONE. Exactly one transaction is outstanding at a time.
  - IDLE/DONE + io_start: latch seed, clear errors, burst index n=0, go to AW. io_busy=1 and io_done=0 from the next cycle.
  - AW: aw_valid=1 with addr = BASE_ADDR + n*BEATS*BYTES, where BYTES = DATA_BITS/8.
    - len = BEATS-1; size = log2(BYTES); id = n mod 2^ID_BITS.
    - valid and payload stay stable until aw_ready; the handshake moves to W.
  - W: beat k (0..BEATS-1) has data = DATA_BITS/32 copies of (beat_addr[31:0] XOR seed), where beat_addr = burst addr + k*BYTES.
    - strb all ones; last=1 only on k=BEATS-1.
    - data stays stable while stalled; the handshake on the last beat moves to B.
  - B: b_ready=1. On b_valid: error if resp!=0 or id mismatch. Then n+1 goes to AW; after the last burst, n=0 and go to AR.
  - AR: same addr/len/size/id rules as AW; handshake moves to R.
  - R: r_ready=1. Each beat is an error if any of the following holds:
    - data != expected
    - resp != 0
    - id mismatch
    - last != (k==BEATS-1)
  - R exit: leaves R on the beat with expected k=BEATS-1, even if last is wrong. Next burst goes to AR; after the final burst, go to DONE.
  - DONE: io_busy=0; io_done=1; io_pass = (error_count==0).
- Error accounting:
  - io_error_count increments by at most 1 per cycle and saturates at 0xFFFF.
  - io_fail_addr is written only on the first error. B errors record the burst address; R errors record the beat address.
- Addresses wrap modulo 2^ADDR_BITS.
- AW valid appears 1 cycle after start. There are no combinational input-to-output paths.

Test Plan:
- Always-ready responder; NUM_BURSTS=2, BEATS=4, seed 0xA5A5A5A5 -> AW at 0x0 and 0x20 with len 3, size 3, ids 0 and 1; W beat 0 = 0xA5A5A5A5A5A5A5A5, beat 1 = 0xA5A5A5ADA5A5A5AD; done=1, pass=1, error_count=0.
- Responder flips bit 0 of the read beat at 0x28 -> error_count=1, fail_addr=0x28, pass=0.
- Random 30% ready on AW/W/AR and random r/b valid gaps -> valid/payload held stable on every stall; same result as the first scenario.
- B resp=2 on burst 1 -> error_count=1, fail_addr=0x20; the read phase still runs.
- Read burst 0 returns last on beat 2 instead of beat 3 -> 2 errors, fail_addr=0x10.
- Reset asserted during W beat 2 -> next cycle all valids 0, busy=0, done=0; a new start then produces a clean pass.
